// File: rtl/kairo_csr_hpm.sv
// kairo_csr_hpm: machine counter CSR unit (mcycle, minstret, mhpmcounterN/mhpmeventN, mcountinhibit).
// Define KAIRO_HPM_OVF_IRQ_EN to add sticky overflow flags (mhpmeventN[31]) and the OVF_IRQ request.
module kairo_csr_hpm #(
  parameter int NUM_HPM    = 4,
  parameter int CNT_WIDTH  = 64,
  parameter int NUM_EVENTS = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [11:0]           csr_addr_i,
  input  logic                  csr_we_i,
  input  logic [31:0]           csr_wdata_i,
  input  logic [31:0]           csr_wmask_i,
  output logic [31:0]           csr_rdata_o,
  output logic                  csr_hit_o,
  input  logic                  retire_i,
  input  logic [NUM_EVENTS-1:0] events_i,
  output logic                  ovf_irq_o
);

  localparam int HPM_ARR = (NUM_HPM > 0) ? NUM_HPM : 1;

  typedef logic [CNT_WIDTH-1:0]  cnt_t;
  typedef logic [NUM_EVENTS-1:0] evt_t;

  function automatic logic [31:0] calcInhMask();
    logic [31:0] m;
    m = 32'h0000_0005;
    for (int i = 0; i < NUM_HPM; i++) m[3+i] = 1'b1;
    return m;
  endfunction

  localparam logic [31:0] INH_MASK = calcInhMask();

  function automatic logic [31:0] maskedWrite(logic [31:0] old, logic [31:0] wdata,
                                              logic [31:0] wmask);
    return (old & ~wmask) | (wdata & wmask);
  endfunction

  // Counters are handled as 64-bit views so bits above CNT_WIDTH read 0 and drop writes.
  function automatic logic [63:0] cntExt(cnt_t c);
    logic [63:0] e;
    e = '0;
    e[CNT_WIDTH-1:0] = c;
    return e;
  endfunction

  function automatic logic [31:0] cntHalf(cnt_t c, logic hi);
    logic [63:0] e;
    e = cntExt(c);
    return hi ? e[63:32] : e[31:0];
  endfunction

  function automatic cnt_t cntNext(cnt_t cur, logic wrLo, logic wrHi, logic inc,
                                   logic [31:0] wdata, logic [31:0] wmask);
    logic [63:0] e;
    cnt_t        n;
    e = cntExt(cur);
    if (wrLo) e[31:0]  = maskedWrite(e[31:0], wdata, wmask);
    if (wrHi) e[63:32] = maskedWrite(e[63:32], wdata, wmask);
    if (wrLo || wrHi) n = e[CNT_WIDTH-1:0];
    else if (inc)     n = cur + cnt_t'(1);
    else              n = cur;
    return n;
  endfunction

  logic [4:0] idx;
  logic       selCntLo, selCntHi, selEvt;

  assign idx      = csr_addr_i[4:0];
  assign selCntLo = (csr_addr_i[11:5] == 7'h58);
  assign selCntHi = (csr_addr_i[11:5] == 7'h5C);
  assign selEvt   = (csr_addr_i[11:5] == 7'h19);

  cnt_t        mcycle_q, mcycle_d;
  cnt_t        minstret_q, minstret_d;
  cnt_t        hpmCnt_q [HPM_ARR];
  cnt_t        hpmCnt_d [HPM_ARR];
  evt_t        hpmEvt_q [HPM_ARR];
  evt_t        hpmEvt_d [HPM_ARR];
  logic [31:0] inhibit_q, inhibit_d;
  logic [31:0] rdata_q, rdata_d;
  logic        hit_q, hit_d;
`ifdef KAIRO_HPM_OVF_IRQ_EN
  logic        hpmOf_q [HPM_ARR];
  logic        hpmOf_d [HPM_ARR];
  logic        ovfIrq_q, ovfIrq_d;
`endif

  // Registered read mux; always reflects state before this cycle's update.
  always_comb begin
    rdata_d = '0;
    hit_d   = 1'b0;
    if (selCntLo || selCntHi) begin
      if (idx == 5'd0) begin
        hit_d   = 1'b1;
        rdata_d = cntHalf(mcycle_q, selCntHi);
      end else if (idx == 5'd2) begin
        hit_d   = 1'b1;
        rdata_d = cntHalf(minstret_q, selCntHi);
      end else if (idx >= 5'd3) begin
        hit_d = 1'b1;
        for (int i = 0; i < NUM_HPM; i++)
          if (idx == 5'(i + 3)) rdata_d = cntHalf(hpmCnt_q[i], selCntHi);
      end
    end else if (selEvt) begin
      if (idx == 5'd0) begin
        hit_d   = 1'b1;
        rdata_d = inhibit_q;
      end else if (idx >= 5'd3) begin
        hit_d = 1'b1;
        for (int i = 0; i < NUM_HPM; i++) begin
          if (idx == 5'(i + 3)) begin
            rdata_d[NUM_EVENTS-1:0] = hpmEvt_q[i];
`ifdef KAIRO_HPM_OVF_IRQ_EN
            rdata_d[31] = hpmOf_q[i];
`endif
          end
        end
      end
    end
  end

  // Counter, event and inhibit next state; a CSR write to a counter replaces its increment.
  always_comb begin
    logic wrLo, wrHi, wrEvt, inc;
    wrLo  = 1'b0;
    wrHi  = 1'b0;
    wrEvt = 1'b0;
    inc   = 1'b0;
    mcycle_d   = cntNext(mcycle_q, csr_we_i && selCntLo && idx == 5'd0,
                         csr_we_i && selCntHi && idx == 5'd0, !inhibit_q[0],
                         csr_wdata_i, csr_wmask_i);
    minstret_d = cntNext(minstret_q, csr_we_i && selCntLo && idx == 5'd2,
                         csr_we_i && selCntHi && idx == 5'd2, retire_i && !inhibit_q[2],
                         csr_wdata_i, csr_wmask_i);
    inhibit_d = inhibit_q;
    if (csr_we_i && selEvt && idx == 5'd0)
      inhibit_d = maskedWrite(inhibit_q, csr_wdata_i, csr_wmask_i) & INH_MASK;
    hpmCnt_d = hpmCnt_q;
    hpmEvt_d = hpmEvt_q;
`ifdef KAIRO_HPM_OVF_IRQ_EN
    hpmOf_d  = hpmOf_q;
    ovfIrq_d = 1'b0;
`endif
    for (int i = 0; i < NUM_HPM; i++) begin
      wrLo  = csr_we_i && selCntLo && idx == 5'(i + 3);
      wrHi  = csr_we_i && selCntHi && idx == 5'(i + 3);
      wrEvt = csr_we_i && selEvt && idx == 5'(i + 3);
      inc   = (|(events_i & hpmEvt_q[i])) && !inhibit_q[i+3];
      hpmCnt_d[i] = cntNext(hpmCnt_q[i], wrLo, wrHi, inc, csr_wdata_i, csr_wmask_i);
      if (wrEvt)
        hpmEvt_d[i] = (hpmEvt_q[i] & ~csr_wmask_i[NUM_EVENTS-1:0]) |
                      (csr_wdata_i[NUM_EVENTS-1:0] & csr_wmask_i[NUM_EVENTS-1:0]);
`ifdef KAIRO_HPM_OVF_IRQ_EN
      ovfIrq_d = ovfIrq_d | hpmOf_q[i];
      if (wrEvt && csr_wmask_i[31]) hpmOf_d[i] = csr_wdata_i[31];
      // Hardware wrap beats a same-cycle software clear.
      if (inc && !wrLo && !wrHi && hpmCnt_q[i] == '1) hpmOf_d[i] = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
      hpmCnt_q   <= '{default: '0};
      hpmEvt_q   <= '{default: '0};
      inhibit_q  <= '0;
      rdata_q    <= '0;
      hit_q      <= 1'b0;
`ifdef KAIRO_HPM_OVF_IRQ_EN
      hpmOf_q    <= '{default: 1'b0};
      ovfIrq_q   <= 1'b0;
`endif
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      hpmCnt_q   <= hpmCnt_d;
      hpmEvt_q   <= hpmEvt_d;
      inhibit_q  <= inhibit_d;
      rdata_q    <= rdata_d;
      hit_q      <= hit_d;
`ifdef KAIRO_HPM_OVF_IRQ_EN
      hpmOf_q    <= hpmOf_d;
      ovfIrq_q   <= ovfIrq_d;
`endif
    end
  end

  assign csr_rdata_o = rdata_q;
  assign csr_hit_o   = hit_q;
`ifdef KAIRO_HPM_OVF_IRQ_EN
  assign ovf_irq_o   = ovfIrq_q;
`else
  assign ovf_irq_o   = 1'b0;
`endif

endmodule

// File: tb/tb_kairo_csr_hpm.sv
// Directed bench for kairo_csr_hpm (NUM_HPM=2); expectations adapt to KAIRO_HPM_OVF_IRQ_EN.
module tb_kairo_csr_hpm;

`ifdef KAIRO_HPM_OVF_IRQ_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] csrAddr;
  logic        csrWe;
  logic [31:0] csrWdata;
  logic [31:0] csrWmask;
  logic [31:0] csrRdata;
  logic        csrHit;
  logic        retire;
  logic [15:0] events;
  logic        ovfIrq;

  int checkCount = 0;
  int failCount  = 0;

  always #5 clk = ~clk;

  kairo_csr_hpm #(
    .NUM_HPM   (2),
    .CNT_WIDTH (64),
    .NUM_EVENTS(16)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .csr_addr_i (csrAddr),
    .csr_we_i   (csrWe),
    .csr_wdata_i(csrWdata),
    .csr_wmask_i(csrWmask),
    .csr_rdata_o(csrRdata),
    .csr_hit_o  (csrHit),
    .retire_i   (retire),
    .events_i   (events),
    .ovf_irq_o  (ovfIrq)
  );

  // One bus cycle: drive, let one rising edge pass, then settle 1 time unit past it.
  task automatic applyStimulus(input logic [11:0] addr, input logic we,
                               input logic [31:0] wdata, input logic [31:0] wmask);
    csrAddr  = addr;
    csrWe    = we;
    csrWdata = wdata;
    csrWmask = wmask;
    @(posedge clk);
    #1;
    csrWe = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic readExpect(input string tag, input logic [11:0] addr,
                            input logic [31:0] expData, input logic expHit);
    applyStimulus(addr, 1'b0, 32'h0, 32'h0);
    checkOutput({tag, " rdata"}, csrRdata, expData);
    checkOutput({tag, " hit"}, {31'b0, csrHit}, {31'b0, expHit});
  endtask

  initial begin
    rst      = 1'b0;
    csrAddr  = '0;
    csrWe    = 1'b0;
    csrWdata = '0;
    csrWmask = '0;
    retire   = 1'b0;
    events   = '0;

    $display("[TB] reset and idle count");
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset rdata", csrRdata, 32'h0);
    checkOutput("reset hit", {31'b0, csrHit}, 32'h0);
    checkOutput("reset ovf", {31'b0, ovfIrq}, 32'h0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    readExpect("mcycle after 10", 12'hB00, 32'd10, 1'b1);
    readExpect("minstret idle", 12'hB02, 32'd0, 1'b1);

    $display("[TB] mcountinhibit and minstret");
    applyStimulus(12'h320, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    readExpect("inhibit mask", 12'h320, 32'h0000_001D, 1'b1);
    applyStimulus(12'h320, 1'b1, 32'h0000_0004, 32'hFFFF_FFFF);
    retire = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    retire = 1'b0;
    readExpect("minstret inhibited", 12'hB02, 32'd0, 1'b1);
    applyStimulus(12'h320, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF);
    retire = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    retire = 1'b0;
    readExpect("minstret counting", 12'hB02, 32'd5, 1'b1);

    $display("[TB] hpm3 wrap");
    applyStimulus(12'hB03, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    applyStimulus(12'hB83, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    applyStimulus(12'h323, 1'b1, 32'h0000_0001, 32'hFFFF_FFFF);
    readExpect("hpmevent3 init", 12'h323, 32'h0000_0001, 1'b1);
    readExpect("hpm3 preset", 12'hB03, 32'hFFFF_FFFF, 1'b1);
    events = 16'h0001;
    @(posedge clk);
    #1;
    events = '0;
    checkOutput("ovf same cycle", {31'b0, ovfIrq}, 32'h0);
    readExpect("hpm3 wrapped lo", 12'hB03, 32'h0, 1'b1);
    checkOutput("ovf after wrap", {31'b0, ovfIrq}, {31'b0, OVF_EN});
    readExpect("hpm3 wrapped hi", 12'hB83, 32'h0, 1'b1);
    readExpect("hpmevent3 OF", 12'h323, OVF_EN ? 32'h8000_0001 : 32'h0000_0001, 1'b1);

    $display("[TB] hpm3 one count per cycle");
    applyStimulus(12'h323, 1'b1, 32'h0000_0003, 32'hFFFF_FFFF);
    events = 16'h0003;
    repeat (2) @(posedge clk);
    #1;
    events = 16'h0004;
    repeat (2) @(posedge clk);
    #1;
    events = '0;
    readExpect("hpm3 multi event", 12'hB03, 32'd2, 1'b1);
    checkOutput("ovf cleared", {31'b0, ovfIrq}, 32'h0);

    $display("[TB] masked mcycle write");
    applyStimulus(12'hB00, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF);
    applyStimulus(12'hB80, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF);
    applyStimulus(12'hB00, 1'b1, 32'h0000_0100, 32'h0000_00FF);
    readExpect("mcycle masked", 12'hB00, 32'h1234_5600, 1'b1);
    readExpect("mcycle resumes", 12'hB00, 32'h1234_5601, 1'b1);
    readExpect("mcycle hi", 12'hB80, 32'h0, 1'b1);

    $display("[TB] unimplemented and foreign addresses");
    readExpect("hpm5 hardwired", 12'hB05, 32'h0, 1'b1);
    readExpect("hpmevent5 hardwired", 12'h325, 32'h0, 1'b1);
    applyStimulus(12'hB05, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    readExpect("hpm5 after write", 12'hB05, 32'h0, 1'b1);
    readExpect("addr 341", 12'h341, 32'h0, 1'b0);
    readExpect("addr B01", 12'hB01, 32'h0, 1'b0);

    $display("[TB] software OF set then reset mid-run");
    applyStimulus(12'h324, 1'b1, 32'h8000_0000, 32'h8000_0000);
    readExpect("hpmevent4 sw OF", 12'h324, OVF_EN ? 32'h8000_0000 : 32'h0, 1'b1);
    checkOutput("ovf sw set", {31'b0, ovfIrq}, {31'b0, OVF_EN});
    retire   = 1'b1;
    events   = 16'h0001;
    csrAddr  = 12'hB03;
    csrWe    = 1'b1;
    csrWdata = 32'h0000_0055;
    csrWmask = 32'hFFFF_FFFF;
    #3 rst = 1'b1;
    #1;
    checkOutput("async rst ovf", {31'b0, ovfIrq}, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("rst rdata", csrRdata, 32'h0);
    checkOutput("rst hit", {31'b0, csrHit}, 32'h0);
    rst    = 1'b0;
    csrWe  = 1'b0;
    retire = 1'b0;
    events = '0;
    readExpect("post-rst mcycle", 12'hB00, 32'h0, 1'b1);
    readExpect("post-rst minstret", 12'hB02, 32'h0, 1'b1);
    readExpect("post-rst hpm3", 12'hB03, 32'h0, 1'b1);
    readExpect("post-rst hpmevent3", 12'h323, 32'h0, 1'b1);
    readExpect("post-rst hpmevent4", 12'h324, 32'h0, 1'b1);
    readExpect("post-rst inhibit", 12'h320, 32'h0, 1'b1);
    checkOutput("post-rst ovf", {31'b0, ovfIrq}, 32'h0);

    $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule
